// File: rtl/cash_reg_pkg.sv
// Shared package for the cash register / change dispenser family.
// Holds the FSM state encoding used by change_dispenser and the coin code
// constants shared with the hopper side.
package cash_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CALC     = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_DONE     = 3'd3,
    ST_SHORT    = 3'd4
  } state_t;

  localparam logic [1:0] COIN_D0 = 2'd0;
  localparam logic [1:0] COIN_D1 = 2'd1;
  localparam logic [1:0] COIN_D2 = 2'd2;
  localparam logic [1:0] COIN_D3 = 2'd3;

endpackage

// File: rtl/change_dispenser_if.sv
// Bus between a payment controller/hopper and change_dispenser.
// Handshake: a coin moves exactly on a cycle where CoinValid & CoinReady are
// both 1 at the rising clock edge; while CoinValid=1 and CoinReady=0 the
// dispenser holds Coin and Remaining stable, and CoinValid never drops
// without a handshake.
// Signals: Load/Paid/Due start a transaction; CoinValid/Coin/CoinReady carry
// coins; Remaining, Busy, Done, Short report status; State is a debug view
// of the FSM. Optional CoinCount exists only when COIN_COUNT_EN is defined.
interface change_dispenser_if #(
  parameter int W = 4
);
  import cash_reg_pkg::*;

  logic         Load;
  logic [W-1:0] Paid;
  logic [W-1:0] Due;
  logic         CoinReady;
  logic         CoinValid;
  logic [1:0]   Coin;
  logic [W-1:0] Remaining;
  logic         Busy;
  logic         Done;
  logic         Short;
`ifdef COIN_COUNT_EN
  logic [W-1:0] CoinCount;
`endif
  state_t       State;

  modport master (
    output Load, Paid, Due, CoinReady,
    input  CoinValid, Coin, Remaining, Busy, Done, Short,
`ifdef COIN_COUNT_EN
           CoinCount,
`endif
           State
  );

  modport slave (
    input  Load, Paid, Due, CoinReady,
    output CoinValid, Coin, Remaining, Busy, Done, Short,
`ifdef COIN_COUNT_EN
           CoinCount,
`endif
           State
  );

endinterface

// File: rtl/add_w.sv
// AddW: W-bit ripple-carry adder shared across the codebase.
// Ports: a_i, b_i operands; c0_i carry-in; s_o sum; ovf_o carry-out.
// Used as a subtractor by feeding ~b and c0=1; ovf_o=1 then means no borrow.
module AddW #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c0_i,
  output logic [W-1:0] s_o,
  output logic         ovf_o
);

  logic [W:0] carry;

  assign carry[0] = c0_i;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign ovf_o = carry[W];

endmodule

// File: rtl/coin_select.sv
// coin_select: greedy coin encoder. Picks the largest denomination that fits
// in the remaining amount.
// Ports: rem_i remaining change; coin_o coin code 3..0 (0 when rem_i is 0,
// which only happens outside DISPENSE).
module coin_select
  import cash_reg_pkg::*;
#(
  parameter int           W    = 4,
  parameter logic [W-1:0] DEN3 = 4'd10,
  parameter logic [W-1:0] DEN2 = 4'd5,
  parameter logic [W-1:0] DEN1 = 4'd2
) (
  input  logic [W-1:0] rem_i,
  output logic [1:0]   coin_o
);

  always_comb begin
    coin_o = COIN_D0;
    if (rem_i >= DEN3)      coin_o = COIN_D3;
    else if (rem_i >= DEN2) coin_o = COIN_D2;
    else if (rem_i >= DEN1) coin_o = COIN_D1;
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: computes change = Paid - Due and pays it out one coin per
// handshake, greedy largest-first.
// Ports: Clock (rising edge), Reset_n (async, active low), bus (slave side of
// change_dispenser_if: Load/Paid/Due in, CoinValid/Coin/CoinReady coin
// handshake, Remaining/Busy/Done/Short status, State debug).
// Optional feature macro: COIN_COUNT_EN adds a per-transaction coin counter
// on bus.CoinCount.
module change_dispenser
  import cash_reg_pkg::*;
#(
  parameter int W    = 4,
  parameter int DEN3 = 10,
  parameter int DEN2 = 5,
  parameter int DEN1 = 2,
  parameter int DEN0 = 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  change_dispenser_if.slave bus
);

  // DEN0 must be 1 so every amount terminates; strict ordering keeps the
  // greedy encoder meaningful.
  if (!(DEN3 < 2**W && DEN3 > DEN2 && DEN2 > DEN1 && DEN1 > DEN0 && DEN0 == 1))
  begin : g_den_check
    $error("change_dispenser: illegal DEN parameter set");
  end

  localparam logic [W-1:0] DEN3_W = DEN3[W-1:0];
  localparam logic [W-1:0] DEN2_W = DEN2[W-1:0];
  localparam logic [W-1:0] DEN1_W = DEN1[W-1:0];
  localparam logic [W-1:0] DEN0_W = DEN0[W-1:0];

  state_t       state_q;
  logic [W-1:0] paid_q, due_q, rem_q;
  logic         valid_q, busy_q, done_q, short_q;

  logic [1:0]   coin;
  logic [W-1:0] den_sel;
  logic [W-1:0] diff;
  logic         no_borrow;
  logic [W-1:0] rem_d;
  logic         pay_ok;
  logic         hs;

  coin_select #(
    .W    (W),
    .DEN3 (DEN3_W),
    .DEN2 (DEN2_W),
    .DEN1 (DEN1_W)
  ) u_coin_select (
    .rem_i  (rem_q),
    .coin_o (coin)
  );

  always_comb begin
    den_sel = DEN0_W;
    case (coin)
      COIN_D3: den_sel = DEN3_W;
      COIN_D2: den_sel = DEN2_W;
      COIN_D1: den_sel = DEN1_W;
      default: den_sel = DEN0_W;
    endcase
  end

  // Paid - Due; carry-out low means Paid < Due.
  AddW #(.W(W)) u_sub_calc (
    .a_i   (paid_q),
    .b_i   (~due_q),
    .c0_i  (1'b1),
    .s_o   (diff),
    .ovf_o (no_borrow)
  );

  // Remaining - DEN[Coin]. The encoder never picks a coin larger than
  // Remaining, so pay_ok is always 1 in DISPENSE; gating on it keeps
  // Remaining from ever wrapping.
  AddW #(.W(W)) u_sub_pay (
    .a_i   (rem_q),
    .b_i   (~den_sel),
    .c0_i  (1'b1),
    .s_o   (rem_d),
    .ovf_o (pay_ok)
  );

  assign hs = valid_q & bus.CoinReady & pay_ok;

`ifdef COIN_COUNT_EN
  logic [W-1:0] count_q;
  assign bus.CoinCount = count_q;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      paid_q  <= '0;
      due_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
`ifdef COIN_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      short_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.Load) begin
            paid_q  <= bus.Paid;
            due_q   <= bus.Due;
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
`ifdef COIN_COUNT_EN
            count_q <= '0;
`endif
          end
        end
        ST_CALC: begin
          if (!no_borrow) begin
            short_q <= 1'b1;
            state_q <= ST_SHORT;
          end else if (diff == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            rem_q   <= diff;
            valid_q <= 1'b1;
            state_q <= ST_DISPENSE;
          end
        end
        ST_DISPENSE: begin
          if (hs) begin
            rem_q <= rem_d;
`ifdef COIN_COUNT_EN
            count_q <= count_q + W'(1);
`endif
            if (rem_d == '0) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE, ST_SHORT: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          rem_q   <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.CoinValid = valid_q;
  assign bus.Coin      = coin;
  assign bus.Remaining = rem_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Short     = short_q;
  assign bus.State     = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: table of directed transactions with
// hand-computed coin sequences, plus hand-written stall, reset and
// ignored-Load sequences.
module tb_change_dispenser;
  import cash_reg_pkg::*;

  logic clk;
  logic rst_n;

  change_dispenser_if #(.W(4)) bus ();

  change_dispenser #(.W(4)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] paid;
    logic [3:0] due;
    logic       short_e;
    logic [1:0] n;
    logic [5:0] coins;  // {c2, c1, c0}
    logic [11:0] rems;  // {r2, r1, r0}: Remaining shown with each coin
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int paid, input int due, input bit sh, input int n,
                              input int c0, input int c1, input int c2,
                              input int r0, input int r1, input int r2);
    vec_t v;
    v.paid    = 4'(paid);
    v.due     = 4'(due);
    v.short_e = sh;
    v.n       = 2'(n);
    v.coins   = {2'(c2), 2'(c1), 2'(c0)};
    v.rems    = {4'(r2), 4'(r1), 4'(r0)};
    return v;
  endfunction

  // Driver: one full transaction with CoinReady held at 1.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    bus.Load = 1'b1; bus.Paid = v.paid; bus.Due = v.due; bus.CoinReady = 1'b1;
    @(negedge clk);  // CALC
    bus.Load = 1'b0;
    check("calc_busy", 32'(bus.Busy), 1);
    check("calc_valid", 32'(bus.CoinValid), 0);
    check("calc_rem", 32'(bus.Remaining), 0);
    @(negedge clk);  // N+2
    if (v.short_e) begin
      check("short_pulse", 32'(bus.Short), 1);
      check("short_valid", 32'(bus.CoinValid), 0);
      check("short_done", 32'(bus.Done), 0);
      check("short_rem", 32'(bus.Remaining), 0);
      @(negedge clk);
      check("short_clear", 32'(bus.Short), 0);
      check("short_busy", 32'(bus.Busy), 0);
    end else begin
      for (int i = 0; i < int'(v.n); i++) begin
        check("coin_valid", 32'(bus.CoinValid), 1);
        check("coin_code", 32'(bus.Coin), 32'(v.coins[i*2 +: 2]));
        check("coin_rem", 32'(bus.Remaining), 32'(v.rems[i*4 +: 4]));
        check("coin_nodone", 32'(bus.Done), 0);
        @(negedge clk);
      end
      check("done_pulse", 32'(bus.Done), 1);
      check("done_valid", 32'(bus.CoinValid), 0);
      check("done_rem", 32'(bus.Remaining), 0);
      check("done_short", 32'(bus.Short), 0);
`ifdef COIN_COUNT_EN
      check("coin_count", 32'(bus.CoinCount), 32'(v.n));
`endif
      @(negedge clk);
      check("done_clear", 32'(bus.Done), 0);
      check("idle_busy", 32'(bus.Busy), 0);
      check("idle_state", 32'(bus.State), 32'(ST_IDLE));
    end
  endtask

  initial begin
    vecs[0] = mk(15, 6, 0, 3, 2, 1, 1, 9, 4, 2);
    vecs[1] = mk(7, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2] = mk(3, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk(15, 0, 0, 2, 3, 2, 0, 15, 5, 0);
    vecs[4] = mk(12, 1, 0, 2, 3, 0, 0, 11, 1, 0);
    vecs[5] = mk(4, 0, 0, 2, 1, 1, 0, 4, 2, 0);
    vecs[6] = mk(8, 5, 0, 2, 1, 0, 0, 3, 1, 0);
    vecs[7] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[8] = mk(14, 0, 0, 3, 3, 1, 1, 14, 4, 2);
    vecs[9] = mk(13, 0, 0, 3, 3, 1, 0, 13, 3, 1);

    rst_n = 1'b0;
    bus.Load = 1'b0; bus.Paid = '0; bus.Due = '0; bus.CoinReady = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.CoinValid), 0);
    check("rst_busy", 32'(bus.Busy), 0);
    check("rst_done", 32'(bus.Done), 0);
    check("rst_short", 32'(bus.Short), 0);
    check("rst_rem", 32'(bus.Remaining), 0);
    check("rst_coin", 32'(bus.Coin), 0);
    check("rst_state", 32'(bus.State), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 10; k++) run_vec(vecs[k]);

    // Stall: 15 - 0 with CoinReady low for 3 cycles.
    @(negedge clk);
    bus.Load = 1'b1; bus.Paid = 4'd15; bus.Due = 4'd0; bus.CoinReady = 1'b0;
    @(negedge clk);
    bus.Load = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(bus.CoinValid), 1);
      check("stall_coin", 32'(bus.Coin), 3);
      check("stall_rem", 32'(bus.Remaining), 15);
      @(negedge clk);
    end
    check("stall_hold_coin", 32'(bus.Coin), 3);
    bus.CoinReady = 1'b1;
    @(negedge clk);
    check("stall_coin2", 32'(bus.Coin), 2);
    check("stall_rem2", 32'(bus.Remaining), 5);
    @(negedge clk);
    check("stall_done", 32'(bus.Done), 1);
    @(negedge clk);

    // Reset in the middle of DISPENSE of 15 - 6.
    bus.Load = 1'b1; bus.Paid = 4'd15; bus.Due = 4'd6; bus.CoinReady = 1'b1;
    @(negedge clk);
    bus.Load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rem", 32'(bus.Remaining), 4);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.CoinValid), 0);
    check("arst_rem", 32'(bus.Remaining), 0);
    check("arst_busy", 32'(bus.Busy), 0);
    check("arst_coin", 32'(bus.Coin), 0);
    check("arst_done", 32'(bus.Done), 0);
    check("arst_state", 32'(bus.State), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_done", 32'(bus.Done), 0);
      check("post_rst_busy", 32'(bus.Busy), 0);
    end
    run_vec(vecs[0]);

    // Load pulsed during DISPENSE of 9 - 0 is ignored.
    @(negedge clk);
    bus.Load = 1'b1; bus.Paid = 4'd9; bus.Due = 4'd0; bus.CoinReady = 1'b0;
    @(negedge clk);
    bus.Load = 1'b0;
    @(negedge clk);
    bus.Load = 1'b1; bus.Paid = 4'd15; bus.Due = 4'd0;
    @(negedge clk);
    bus.Load = 1'b0;
    check("ign_rem", 32'(bus.Remaining), 9);
    check("ign_coin", 32'(bus.Coin), 2);
    check("ign_state", 32'(bus.State), 32'(ST_DISPENSE));
    bus.CoinReady = 1'b1;
    @(negedge clk);
    check("ign_rem1", 32'(bus.Remaining), 4);
    check("ign_coin1", 32'(bus.Coin), 1);
    @(negedge clk);
    check("ign_rem2", 32'(bus.Remaining), 2);
    @(negedge clk);
    check("ign_done", 32'(bus.Done), 1);
`ifdef COIN_COUNT_EN
    check("ign_count", 32'(bus.CoinCount), 3);
`endif
    @(negedge clk);
    check("ign_idle", 32'(bus.Busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
